// File: rtl/mips32_instr_sequencer.sv
// mips32_instr_sequencer
//   Runs a small stored program of 32-bit R-type instructions through the
//   single-cycle mips32 datapath. Each instruction is held on `instruction`
//   for SETTLE cycles, then `dp_result` is captured and emitted as a tagged
//   result. A `done` pulse marks the end of the run.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   load_en/addr/data   program write port, ignored while busy
//   prog_len, start     run request (prog_len sampled with start while idle)
//   hold                freezes issue and capture during a run
//   busy, done, error   run status; done/error are one-cycle pulses
//   instruction         registered instruction driven to the datapath
//   dp_result           combinational datapath result
//   res_valid/data/index captured result stream
module mips32_instr_sequencer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       instruction,
    input  logic [31:0]       dp_result,
    output logic              res_valid,
    output logic [31:0]       res_data,
    output logic [ADDR_W-1:0] res_index
);

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [7:0]        CNT_LAST = 8'(SETTLE - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE  = 1;
    localparam logic [ADDR_W-1:0] PC_ONE   = 1;

    logic [31:0]       mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] last_pc;   // len-1, kept instead of len so the end test is a plain compare
    logic [7:0]        cnt;
    logic [31:0]       first_instr;

    // A write to slot 0 in the same cycle as start must be seen by the run.
    assign first_instr = (load_en && load_addr == '0) ? load_data : mem[0];

    // Program storage: deliberately outside reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (load_en && !busy)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            res_valid   <= 1'b0;
            instruction <= '0;
            res_data    <= '0;
            res_index   <= '0;
            pc          <= '0;
            last_pc     <= '0;
            cnt         <= '0;
        end else begin
            done      <= 1'b0;
            error     <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (prog_len > DEPTH_L) begin
                            error <= 1'b1;
                        end else if (prog_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            last_pc     <= ADDR_W'(prog_len - LEN_ONE);
                            pc          <= '0;
                            cnt         <= '0;
                            instruction <= first_instr;
                            busy        <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!hold) begin
                        if (cnt != CNT_LAST) begin
                            cnt <= cnt + 8'd1;
                        end else begin
                            res_data  <= dp_result;
                            res_index <= pc;
                            res_valid <= 1'b1;
                            cnt       <= '0;
                            if (pc == last_pc) begin
                                done        <= 1'b1;
                                busy        <= 1'b0;
                                instruction <= '0;
                                state       <= IDLE;
                            end else begin
                                pc          <= pc + PC_ONE;
                                instruction <= mem[pc + PC_ONE];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_instr_sequencer.sv
// Bench for mips32_instr_sequencer: two instances (SETTLE=1 and SETTLE=3)
// share one stimulus stream; each datapath stub is ~instruction. A
// behavioural model counts active (non-hold) run cycles per instance and
// derives every output from that count; one negedge process compares all
// outputs every cycle, and directed sections pin literal expectations.
module tb_mips32_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic        hold = 1'b0;

    logic [1:0]        d_busy, d_done, d_err, d_rv;
    logic [1:0][31:0]  d_ins, d_rd, d_dp;
    logic [1:0][3:0]   d_ri;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign d_dp[0] = ~d_ins[0];
    assign d_dp[1] = ~d_ins[1];

    mips32_instr_sequencer #(.DEPTH(16), .ADDR_W(4), .SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start), .hold(hold),
        .busy(d_busy[0]), .done(d_done[0]), .error(d_err[0]),
        .instruction(d_ins[0]), .dp_result(d_dp[0]), .res_valid(d_rv[0]),
        .res_data(d_rd[0]), .res_index(d_ri[0]));

    mips32_instr_sequencer #(.DEPTH(16), .ADDR_W(4), .SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start), .hold(hold),
        .busy(d_busy[1]), .done(d_done[1]), .error(d_err[1]),
        .instruction(d_ins[1]), .dp_result(d_dp[1]), .res_valid(d_rv[1]),
        .res_data(d_rd[1]), .res_index(d_ri[1]));

    task automatic chk(input string nm, input int s, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst%0d] @cyc %0d: got %h want %h", nm, s, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mm [2][16];
    logic        mb [2] = '{0, 0};
    int          mk [2] = '{0, 0};   // active run cycles elapsed
    int          ml [2] = '{0, 0};
    logic [31:0] e_ins [2] = '{0, 0};
    logic        e_done [2] = '{0, 0};
    logic        e_err [2] = '{0, 0};
    logic        e_rv [2] = '{0, 0};
    logic [31:0] e_rd [2] = '{0, 0};
    logic [3:0]  e_ri [2] = '{0, 0};

    always @(posedge clk or posedge rst) begin
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                mb[s] = 0; mk[s] = 0; ml[s] = 0; e_ins[s] = 0;
                e_done[s] = 0; e_err[s] = 0; e_rv[s] = 0; e_rd[s] = 0; e_ri[s] = 0;
            end else begin
                int sl, idx;
                sl = (s == 0) ? 1 : 3;
                e_done[s] = 0; e_err[s] = 0; e_rv[s] = 0;
                if (!mb[s]) begin
                    if (load_en) mm[s][load_addr] = load_data;
                    if (start) begin
                        if (prog_len > 16) e_err[s] = 1;
                        else if (prog_len == 0) e_done[s] = 1;
                        else begin
                            mb[s] = 1; mk[s] = 0; ml[s] = int'(prog_len); e_ins[s] = mm[s][0];
                        end
                    end
                end else if (!hold) begin
                    idx = mk[s] / sl;
                    if ((mk[s] + 1) % sl == 0) begin
                        e_rv[s] = 1; e_rd[s] = ~e_ins[s]; e_ri[s] = 4'(idx);
                        if (idx == ml[s] - 1) begin
                            e_done[s] = 1; mb[s] = 0; e_ins[s] = 0;
                        end else begin
                            e_ins[s] = mm[s][idx + 1];
                        end
                    end
                    mk[s]++;
                end
            end
        end
    end

    // ---------------- per-cycle compare + result logs ----------------
    logic [31:0] rd0[$], rd1[$];
    int          ri0[$], ri1[$], rc0[$], rc1[$];
    int          bc0 = 0, bc1 = 0;

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            chk("busy", s, 32'(d_busy[s]), 32'(mb[s]));
            chk("done", s, 32'(d_done[s]), 32'(e_done[s]));
            chk("error", s, 32'(d_err[s]), 32'(e_err[s]));
            chk("res_valid", s, 32'(d_rv[s]), 32'(e_rv[s]));
            chk("instruction", s, d_ins[s], e_ins[s]);
            chk("res_data", s, d_rd[s], e_rd[s]);
            chk("res_index", s, 32'(d_ri[s]), 32'(e_ri[s]));
        end
        if (d_rv[0]) begin rd0.push_back(d_rd[0]); ri0.push_back(int'(d_ri[0])); rc0.push_back(cyc); end
        if (d_rv[1]) begin rd1.push_back(d_rd[1]); ri1.push_back(int'(d_ri[1])); rc1.push_back(cyc); end
        if (d_busy[0]) bc0++;
        if (d_busy[1]) bc1++;
    end

    // ---------------- stimulus ----------------
    logic [31:0] prog [4] = '{32'h00430020, 32'h00434820, 32'h00435021, 32'h00435824};
    logic [31:0] bas  [4] = '{32'hFFBCFFDF, 32'hFFBCB7DF, 32'hFFBCAFDE, 32'hFFBCA7DB};
    int e0;

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic clear_logs();
        rd0.delete(); rd1.delete(); ri0.delete(); ri1.delete(); rc0.delete(); rc1.delete();
        bc0 = 0; bc1 = 0;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        load_en = 1; load_addr = 4'(a); load_data = d; tick(); load_en = 0;
    endtask

    task automatic run(input int len);
        prog_len = 5'(len); start = 1; tick(); start = 0; e0 = cyc;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((d_busy != 2'b00) && n < 300) begin tick(); n++; end
        if (d_busy != 2'b00) chk({nm, "_timeout"}, 0, 32'(d_busy), 0);
        tick();
    endtask

    task automatic chk_basic(input string nm);
        chk({nm, "_count"}, 0, rd0.size(), 4);
        chk({nm, "_count"}, 1, rd1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rd0.size()) begin
                chk({nm, "_data"}, 0, rd0[i], bas[i]);
                chk({nm, "_index"}, 0, ri0[i], i);
            end
            if (i < rd1.size()) begin
                chk({nm, "_data"}, 1, rd1[i], bas[i]);
                chk({nm, "_index"}, 1, ri1[i], i);
            end
        end
    endtask

    initial begin
        // reset
        repeat (3) tick();
        rst = 0;
        tick();
        for (int s = 0; s < 2; s++) begin
            chk("rst_busy", s, 32'(d_busy[s]), 0);
            chk("rst_instr", s, d_ins[s], 0);
            chk("rst_res_data", s, d_rd[s], 0);
        end

        // basic run
        for (int i = 0; i < 4; i++) load(i, prog[i]);
        for (int i = 4; i < 16; i++) load(i, $urandom);
        clear_logs();
        run(4);
        wait_idle("basic");
        chk_basic("basic");
        chk("basic_busy_cycles", 0, bc0, 4);
        chk("basic_busy_cycles", 1, bc1, 12);
        if (rc0.size() == 4) chk("basic_first_capture", 0, rc0[0] - e0, 1);

        // settle and hold: hold sampled on the two edges after E0
        clear_logs();
        run(2);
        hold = 1;
        tick(); chk("hold_instr", 1, d_ins[1], 32'h00430020);
        tick(); chk("hold_instr", 1, d_ins[1], 32'h00430020);
        hold = 0;
        wait_idle("hold");
        chk("hold_count", 1, rc1.size(), 2);
        if (rc1.size() == 2) begin
            chk("hold_slot0_cyc", 1, rc1[0] - e0, 5);
            chk("hold_slot1_cyc", 1, rc1[1] - e0, 8);
        end
        if (rc0.size() == 2) chk("hold_slot0_cyc", 0, rc0[0] - e0, 3);

        // zero-length and over-length runs
        clear_logs();
        run(0);
        for (int s = 0; s < 2; s++) begin
            chk("len0_done", s, 32'(d_done[s]), 1);
            chk("len0_busy", s, 32'(d_busy[s]), 0);
        end
        run(17);
        for (int s = 0; s < 2; s++) begin
            chk("len17_error", s, 32'(d_err[s]), 1);
            chk("len17_busy", s, 32'(d_busy[s]), 0);
        end
        tick();
        chk("len0_17_no_results", 0, rd0.size() + rd1.size(), 0);

        // full-depth run
        clear_logs();
        run(16);
        wait_idle("len16");
        chk("len16_count", 0, rd0.size(), 16);
        chk("len16_count", 1, rd1.size(), 16);
        for (int i = 0; i < 16 && i < ri0.size(); i++) chk("len16_index", 0, ri0[i], i);

        // load and start in the same idle cycle
        clear_logs();
        load_en = 1; load_addr = 0; load_data = 32'h12345678;
        run(1);
        load_en = 0;
        wait_idle("ldstart");
        if (rd0.size() == 1) chk("ldstart_data", 0, rd0[0], 32'hEDCBA987);
        else chk("ldstart_count", 0, rd0.size(), 1);
        load(0, prog[0]);

        // protection: load and start while busy are ignored
        clear_logs();
        run(4);
        load_en = 1; load_addr = 1; load_data = 32'hDEADBEEF; start = 1; prog_len = 4;
        tick();
        load_en = 0; start = 0;
        wait_idle("protect");
        chk_basic("protect_run1");
        clear_logs();
        run(4);
        wait_idle("protect2");
        chk_basic("protect_run2");

        // reset mid-run, after slot 1 of the SETTLE=3 instance is captured
        clear_logs();
        run(4);
        for (int n = 0; n < 50 && rd1.size() < 2; n++) tick();
        rst = 1;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("midrst_busy", s, 32'(d_busy[s]), 0);
            chk("midrst_instr", s, d_ins[s], 0);
            chk("midrst_res_valid", s, 32'(d_rv[s]), 0);
        end
        tick();
        rst = 0;
        tick();
        clear_logs();
        run(4);
        wait_idle("rerun");
        chk_basic("rerun");

        // back-to-back: restart in the done cycle of the SETTLE=1 instance
        clear_logs();
        run(4);
        for (int n = 0; n < 50; n++) begin
            if (d_done[0]) begin
                prog_len = 4; start = 1; tick(); start = 0;
                break;
            end
            tick();
        end
        wait_idle("b2b");
        chk("b2b_count", 0, rd0.size(), 8);
        chk("b2b_count", 1, rd1.size(), 4);
        for (int i = 0; i < 4 && rd0.size() == 8; i++) chk("b2b_data", 0, rd0[4 + i], bas[i]);

        // random traffic, checked cycle by cycle against the model
        for (int n = 0; n < 400; n++) begin
            load_en   = ($urandom % 4) == 0;
            load_addr = 4'($urandom);
            load_data = $urandom;
            start     = ($urandom % 6) == 0;
            prog_len  = 5'($urandom_range(0, 17));
            hold      = ($urandom % 4) == 0;
            tick();
        end
        load_en = 0; start = 0; hold = 0;
        wait_idle("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
